// File: rtl/vga_timing_decoder.sv
// Receive-side VGA timing monitor: rebuilds hCount/vCount from hSync/vSync,
// checks line/frame geometry, reports lock state and timing/bright violations.
module vga_timing_decoder #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned H_ACT_START = 144,
  parameter int unsigned H_ACT_END   = 782,
  parameter int unsigned V_ACT_START = 35,
  parameter int unsigned V_ACT_END   = 513,
  parameter int unsigned LOCK_LINES  = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       hSync,
  input  logic       vSync,
  input  logic       Bright,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       locked,
  output logic       frameStart,
  output logic       pixelValid,
  output logic       timingErr,
  output logic       brightErr,
  output logic [7:0] errCount
);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
  localparam logic [9:0] HA_S     = 10'(H_ACT_START);
  localparam logic [9:0] HA_E     = 10'(H_ACT_END);
  localparam logic [9:0] VA_S     = 10'(V_ACT_START);
  localparam logic [9:0] VA_E     = 10'(V_ACT_END);
  localparam logic [7:0] LOCK_N   = 8'(LOCK_LINES);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t     state, state_nx;
  logic       hs_q, vs_q, bright_q;
  logic       v_seen, v_seen_nx;
  logic [9:0] h_low, h_low_nx, v_low, v_low_nx;
  logic [9:0] h_nx, v_nx;
  logic [7:0] good, good_nx, good_inc;
  logic [8:0] err_sum;
  logic       h_fall, h_rise, v_fall, v_rise, checking;
  logic       line_err, hw_err, vpos_err, frame_err, vw_err, viol;
  logic       in_window;

  always_comb begin
    h_fall   = hs_q & ~hSync;
    h_rise   = ~hs_q & hSync;
    v_fall   = vs_q & ~vSync;
    v_rise   = ~vs_q & vSync;
    checking = (state != SEARCH);
    line_err  = checking & h_fall & (hCount != H_LAST);
    hw_err    = checking & h_rise & (h_low != H_SYNC_W);
    vpos_err  = checking & v_fall & ~h_fall;
    // Vertical phase is unknown until a vSync fall has been seen after acquiring.
    frame_err = checking & v_seen & v_fall & (vCount != V_LAST);
    vw_err    = checking & v_seen & v_rise & (v_low != V_SYNC_W);
    viol      = line_err | hw_err | vpos_err | frame_err | vw_err;
  end

  always_comb begin
    h_nx = (h_fall || hCount == H_LAST) ? '0 : hCount + 10'd1;
    v_nx = vCount;
    if (h_fall) begin
      if (state == SEARCH || v_fall) v_nx = '0;
      else if (vCount == V_LAST)     v_nx = '0;
      else                           v_nx = vCount + 10'd1;
    end
    h_low_nx = h_low;
    if (h_fall)                          h_low_nx = 10'd1;
    else if (!hSync && h_low != '1)      h_low_nx = h_low + 10'd1;
    v_low_nx = v_low;
    if (v_fall)                          v_low_nx = {9'd0, h_fall};
    else if (h_fall && !vSync && v_low != '1) v_low_nx = v_low + 10'd1;
  end

  always_comb begin
    state_nx  = state;
    good_nx   = good;
    v_seen_nx = v_seen;
    good_inc  = (good == '1) ? good : good + 8'd1;
    case (state)
      SEARCH: begin
        if (h_fall) begin
          state_nx  = ACQUIRE;
          good_nx   = '0;
          v_seen_nx = v_fall;
        end
      end
      ACQUIRE: begin
        if (h_fall && v_fall) v_seen_nx = 1'b1;
        if (viol) begin
          good_nx = '0;
        end else if (h_fall) begin
          good_nx = good_inc;
          if (good_inc >= LOCK_N && (v_seen || v_fall)) state_nx = LOCKED;
        end
      end
      LOCKED: begin
        if (viol) state_nx = SEARCH;
      end
      default: state_nx = SEARCH;
    endcase
  end

  // Bright is delayed one clock so it lines up with the recovered counters.
  always_comb begin
    locked     = (state == LOCKED);
    in_window  = (hCount >= HA_S) && (hCount <= HA_E) &&
                 (vCount >= VA_S) && (vCount <= VA_E);
    pixelValid = locked & bright_q & in_window;
    brightErr  = locked & (bright_q ^ in_window);
    frameStart = locked & (hCount == '0) & (vCount == '0);
    err_sum    = 9'(errCount) + 9'(timingErr) + 9'(brightErr);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= SEARCH;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      bright_q  <= 1'b0;
      hCount    <= '0;
      vCount    <= '0;
      h_low     <= '0;
      v_low     <= '0;
      good      <= '0;
      v_seen    <= 1'b0;
      timingErr <= 1'b0;
      errCount  <= '0;
    end else begin
      state     <= state_nx;
      hs_q      <= hSync;
      vs_q      <= vSync;
      bright_q  <= Bright;
      hCount    <= h_nx;
      vCount    <= v_nx;
      h_low     <= h_low_nx;
      v_low     <= v_low_nx;
      good      <= good_nx;
      v_seen    <= v_seen_nx;
      timingErr <= viol;
      errCount  <= err_sum[8] ? '1 : err_sum[7:0];
    end
  end

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Directed bench for vga_timing_decoder on a reduced 40x20 geometry
// (table of single-cycle vectors plus hand-written stream sequences).
module tb_vga_timing_decoder;

  localparam int HT = 40, HS = 6, VT = 20, VS = 2;
  localparam int HAS = 10, HAE = 36, VAS = 4, VAE = 17, LK = 4;

  logic       Clk = 1'b0;
  logic       Reset, hSync, vSync, Bright;
  logic [9:0] hCount, vCount;
  logic       locked, frameStart, pixelValid, timingErr, brightErr;
  logic [7:0] errCount;

  int checks = 0;
  int errors = 0;

  int sh, sv, line_len, hs_w, last_sh, last_sv;
  bit kill;

  vga_timing_decoder #(
    .H_TOTAL(HT), .H_SYNC(HS), .V_TOTAL(VT), .V_SYNC(VS),
    .H_ACT_START(HAS), .H_ACT_END(HAE), .V_ACT_START(VAS), .V_ACT_END(VAE),
    .LOCK_LINES(LK)
  ) dut (
    .Clk(Clk), .Reset(Reset), .hSync(hSync), .vSync(vSync), .Bright(Bright),
    .hCount(hCount), .vCount(vCount), .locked(locked), .frameStart(frameStart),
    .pixelValid(pixelValid), .timingErr(timingErr), .brightErr(brightErr),
    .errCount(errCount)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic rst, hs, vs;
    int   h, v, terr, ec;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit win(input int h, input int v);
    return (h >= HAS) && (h <= HAE) && (v >= VAS) && (v <= VAE);
  endfunction

  task automatic src_cycle();
    hSync  = (sh >= hs_w);
    vSync  = (sv >= VS);
    Bright = win(sh, sv) && !kill;
    @(posedge Clk); #1;
    last_sh = sh;
    last_sv = sv;
    if (sh >= line_len - 1) begin
      sh = 0;
      sv = (sv + 1) % VT;
      line_len = HT;
      hs_w = HS;
    end else begin
      sh++;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hCount"}, int'(hCount), 0);
    chk({tag, "_vCount"}, int'(vCount), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_frameStart"}, int'(frameStart), 0);
    chk({tag, "_pixelValid"}, int'(pixelValid), 0);
    chk({tag, "_timingErr"}, int'(timingErr), 0);
    chk({tag, "_brightErr"}, int'(brightErr), 0);
    chk({tag, "_errCount"}, int'(errCount), 0);
  endtask

  task automatic reset_dut();
    Reset = 1'b1; hSync = 1'b1; vSync = 1'b1; Bright = 1'b0; kill = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk_all_zero("reset");
    Reset = 1'b0;
    line_len = HT;
    hs_w = HS;
  endtask

  initial begin
    vec_t tbl[9];
    bool_t_dummy: begin end
    tbl[0] = '{1'b1, 1'b1, 1'b1, 0, 0, 0, 0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1, 0, 0, 0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 2, 0, 0, 0};  // vSync fall in SEARCH: ignored
    tbl[3] = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 0};  // hFall: ACQUIRE, counters 0
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1, 0, 1, 0};  // 1-clock hSync pulse
    tbl[5] = '{1'b0, 1'b1, 1'b1, 2, 0, 0, 1};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 3, 0, 1, 1};  // vSync fall without hFall
    tbl[7] = '{1'b0, 1'b1, 1'b0, 4, 0, 0, 2};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 0, 0, 0, 0};  // reset mid-stream

    Bright = 1'b0;
    kill = 1'b0;
    for (int i = 0; i < 9; i++) begin
      Reset = tbl[i].rst; hSync = tbl[i].hs; vSync = tbl[i].vs;
      @(posedge Clk); #1;
      chk($sformatf("vec%0d_hCount", i), int'(hCount), tbl[i].h);
      chk($sformatf("vec%0d_vCount", i), int'(vCount), tbl[i].v);
      chk($sformatf("vec%0d_timingErr", i), int'(timingErr), tbl[i].terr);
      chk($sformatf("vec%0d_errCount", i), int'(errCount), tbl[i].ec);
      chk($sformatf("vec%0d_locked", i), int'(locked), 0);
    end

    // Ideal stream from frame start, two frames.
    reset_dut();
    sh = 0; sv = 0;
    for (int n = 0; n < 2 * HT * VT; n++) begin
      bit exp_lock;
      src_cycle();
      exp_lock = (n >= LK * HT);
      chk("t1_hCount", int'(hCount), last_sh);
      chk("t1_vCount", int'(vCount), last_sv);
      chk("t1_timingErr", int'(timingErr), 0);
      chk("t1_brightErr", int'(brightErr), 0);
      chk("t1_locked", int'(locked), int'(exp_lock));
      chk("t1_pixelValid", int'(pixelValid), int'(exp_lock && win(last_sh, last_sv)));
      chk("t1_frameStart", int'(frameStart), int'(exp_lock && last_sh == 0 && last_sv == 0));
    end
    chk("t1_errCount", int'(errCount), 0);

    // Short line (HT-1 clocks) while locked.
    while (!(sh == 0 && sv == 5)) src_cycle();
    line_len = HT - 1;
    repeat (HT - 1) src_cycle();
    src_cycle();
    chk("t2_timingErr_pulse", int'(timingErr), 1);
    chk("t2_locked_drop", int'(locked), 0);
    src_cycle();
    chk("t2_timingErr_clear", int'(timingErr), 0);
    chk("t2_errCount", int'(errCount), 1);
    begin
      bit seen = 1'b0;
      for (int n = 0; n < 2 * HT * VT && !seen; n++) begin
        src_cycle();
        if (last_sh == 0 && last_sv == 0) seen = 1'b1;
        else chk("t2_locked_wait", int'(locked), 0);
        chk("t2_no_timingErr", int'(timingErr), 0);
      end
      chk("t2_relock_seen", int'(seen), 1);
      chk("t2_relocked", int'(locked), 1);
      chk("t2_errCount_hold", int'(errCount), 1);
    end

    // hSync one clock short while locked.
    while (!(sh == 0 && sv == 3)) begin
      src_cycle();
      chk("t3_pre_timingErr", int'(timingErr), 0);
    end
    chk("t3_pre_locked", int'(locked), 1);
    hs_w = HS - 1;
    repeat (HS) src_cycle();
    chk("t3_timingErr_pulse", int'(timingErr), 1);
    chk("t3_locked_drop", int'(locked), 0);
    src_cycle();
    chk("t3_timingErr_clear", int'(timingErr), 0);
    src_cycle();
    chk("t3_errCount", int'(errCount), 2);
    repeat (10) begin
      src_cycle();
      chk("t3_search_locked", int'(locked), 0);
      chk("t3_search_timingErr", int'(timingErr), 0);
    end

    // Single-clock Bright dropout inside the active window.
    reset_dut();
    sh = 0; sv = 0;
    while (!(sh == 20 && sv == 10)) src_cycle();
    chk("t4_locked_before", int'(locked), 1);
    kill = 1'b1;
    src_cycle();
    kill = 1'b0;
    chk("t4_hCount", int'(hCount), 20);
    chk("t4_brightErr", int'(brightErr), 1);
    chk("t4_pixelValid", int'(pixelValid), 0);
    chk("t4_locked", int'(locked), 1);
    src_cycle();
    chk("t4_brightErr_clear", int'(brightErr), 0);
    chk("t4_pixelValid_next", int'(pixelValid), 1);
    src_cycle();
    chk("t4_errCount", int'(errCount), 1);
    chk("t4_locked_after", int'(locked), 1);
    chk("t4_timingErr", int'(timingErr), 0);

    // Stream starting mid-frame.
    reset_dut();
    sh = 27; sv = 15;
    begin
      bit seen = 1'b0;
      for (int n = 0; n < 2 * HT && !seen; n++) begin
        src_cycle();
        chk("t6_search_timingErr", int'(timingErr), 0);
        chk("t6_search_locked", int'(locked), 0);
        if (last_sh == 0) seen = 1'b1;
      end
      chk("t6_hfall_seen", int'(seen), 1);
      chk("t6_hCount_sync", int'(hCount), 0);
      seen = 1'b0;
      for (int n = 0; n < 2 * HT * VT && !seen; n++) begin
        src_cycle();
        chk("t6_acq_timingErr", int'(timingErr), 0);
        if (last_sh == 0 && last_sv == 0) seen = 1'b1;
        else chk("t6_acq_locked", int'(locked), 0);
      end
      chk("t6_vfall_seen", int'(seen), 1);
      chk("t6_locked", int'(locked), 1);
      chk("t6_vCount", int'(vCount), 0);
      chk("t6_errCount", int'(errCount), 0);
    end

    // Flood of violations, then reset mid-line.
    vSync = 1'b1;
    Bright = 1'b0;
    for (int i = 0; i < 400; i++) begin
      hSync = (i % 2 == 1);
      @(posedge Clk); #1;
    end
    chk("t5_errCount_sat", int'(errCount), 255);
    for (int i = 0; i < 7; i++) begin
      hSync = (i % 2 == 1);
      @(posedge Clk); #1;
    end
    chk("t5_errCount_hold", int'(errCount), 255);
    Reset = 1'b1;
    hSync = 1'b0;
    @(posedge Clk); #1;
    chk_all_zero("t5_reset");
    Reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
